if_stage: RTL and testbench

//  Instruction-fetch stage of the MIPS CPU. Owns the program counter, addresses
//  the combinational instruction memory and computes PC+4. Captures the fetched

---
 rtl/if_stage.sv | 121 ++++++++++++
 tb/tb_if_stage.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, addresses the combinational
// instruction memory and registers the fetched word into the IF/ID
// register, which is handed to decode over a valid/ready handshake.
// Redirects flush the wrong-path word; a misaligned redirect target
// parks the stage in FAULT until reset.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_inst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        id_ready,
    output logic        id_valid,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc4,
    output logic        fetch_fault
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FAULT = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        valid_q, valid_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] idpc_q, idpc_d;
    logic [31:0] idpc4_q, idpc4_d;
    logic        fault_q, fault_d;

    logic [31:0] pc_plus4;
    logic        advance;
    logic        target_aligned;

    assign pc_plus4       = pc_q + 32'd4;
    assign advance        = !valid_q || id_ready;
    assign target_aligned = (redirect_pc[1:0] == 2'b00);

    // Next-state: redirect beats advance beats stall; IF/ID holds by default
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        inst_d  = inst_q;
        idpc_d  = idpc_q;
        idpc4_d = idpc4_q;
        fault_d = fault_q;

        case (state_q)
            S_IDLE: begin
                state_d = S_RUN;
            end

            S_RUN: begin
                if (redirect_valid) begin
                    // Any word sitting in IF/ID is wrong-path once a redirect is
                    // taken, so it is dropped even if decode is not ready.
                    valid_d = 1'b0;
                    inst_d  = NOP_INST;
                    if (target_aligned) begin
                        pc_d = redirect_pc;
                    end else begin
                        state_d = S_FAULT;
                        fault_d = 1'b1;
                    end
                end else if (advance) begin
                    inst_d  = imem_inst;
                    idpc_d  = pc_q;
                    idpc4_d = pc_plus4;
                    valid_d = 1'b1;
                    pc_d    = pc_plus4;
                end
            end

            S_FAULT: begin
                valid_d = 1'b0;
                inst_d  = NOP_INST;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and IF/ID registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            valid_q <= 1'b0;
            inst_q  <= NOP_INST;
            idpc_q  <= '0;
            idpc4_q <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
            inst_q  <= inst_d;
            idpc_q  <= idpc_d;
            idpc4_q <= idpc4_d;
            fault_q <= fault_d;
        end
    end

    assign imem_addr   = pc_q;
    assign id_valid    = valid_q;
    assign id_inst     = inst_q;
    assign id_pc       = idpc_q;
    assign id_pc4      = idpc4_q;
    assign fetch_fault = fault_q;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios followed by random stimulus.
// A reference model predicts the stream of instructions decode should
// receive; a monitor compares them as the DUT hands them over.
module tb_if_stage;

    localparam logic [31:0] RPC = 32'h0000_0000;
    localparam logic [31:0] NOP = 32'h0000_0000;
    localparam logic [31:0] KEY = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] imem_addr;
    logic [31:0] imem_inst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_ready;
    logic        id_valid;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
    logic [31:0] id_pc4;
    logic        fetch_fault;

    if_stage #(
        .RESET_PC(RPC),
        .NOP_INST(NOP)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_addr     (imem_addr),
        .imem_inst     (imem_inst),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .id_ready      (id_ready),
        .id_valid      (id_valid),
        .id_inst       (id_inst),
        .id_pc         (id_pc),
        .id_pc4        (id_pc4),
        .fetch_fault   (fetch_fault)
    );

    always #5 clk = ~clk;

    // Instruction memory: word content derived from its address
    assign imem_inst = imem_addr ^ KEY;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] pc4;
    } xfer_t;

    xfer_t       exp_q[$];
    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    // Reference model state
    logic [31:0] m_nf;          // address the next fetch will use
    bit          m_live  = 1'b0;
    bit          m_boot  = 1'b0; // one quiet cycle after reset release
    bit          m_fault = 1'b0;
    bit          m_fresh = 1'b0; // no fetch since reset: id_pc/id_pc4 still 0

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: evolves at each active edge from the inputs applied in that cycle
    initial begin
        xfer_t e;
        m_nf = RPC;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                exp_q.delete();
                m_nf    = RPC;
                m_live  = 1'b1;
                m_boot  = 1'b1;
                m_fault = 1'b0;
                m_fresh = 1'b1;
            end else if (m_live) begin
                if (m_boot) begin
                    m_boot = 1'b0;
                end else if (!m_fault) begin
                    if (redirect_valid) begin
                        exp_q.delete();
                        if (redirect_pc[1:0] == 2'b00) m_nf = redirect_pc;
                        else m_fault = 1'b1;
                    end else if (exp_q.size() == 0) begin
                        e.pc   = m_nf;
                        e.inst = m_nf ^ KEY;
                        e.pc4  = m_nf + 32'd4;
                        exp_q.push_back(e);
                        m_nf    = m_nf + 32'd4;
                        m_fresh = 1'b0;
                    end
                end
            end
        end
    end

    // Monitor: compares outputs mid-cycle and retires handed-over words
    initial begin
        bit e_v;
        forever begin
            @(negedge clk);
            if (m_live) begin
                e_v = (exp_q.size() != 0);
                check32("id_valid", {31'b0, id_valid}, {31'b0, e_v});
                check32("fetch_fault", {31'b0, fetch_fault}, {31'b0, m_fault});
                check32("imem_addr", imem_addr, m_nf);
                if (e_v) begin
                    check32("id_pc", id_pc, exp_q[0].pc);
                    check32("id_inst", id_inst, exp_q[0].inst);
                    check32("id_pc4", id_pc4, exp_q[0].pc4);
                    if (id_ready) void'(exp_q.pop_front());
                end else begin
                    check32("id_inst_nop", id_inst, NOP);
                    if (m_fresh) begin
                        check32("id_pc_rst", id_pc, 32'h0);
                        check32("id_pc4_rst", id_pc4, 32'h0);
                    end
                end
            end
        end
    end

    task automatic cyc(input bit r, input bit rv, input logic [31:0] rpc, input bit rdy);
        @(posedge clk);
        #1;
        rst_n          = r;
        redirect_valid = rv;
        redirect_pc    = rpc;
        id_ready       = rdy;
    endtask

    task automatic run(input int unsigned n, input bit rdy);
        for (int unsigned i = 0; i < n; i++) cyc(1'b1, 1'b0, 32'h0, rdy);
    endtask

    initial begin
        logic [31:0] t;
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        id_ready       = 1'b1;

        // Reset, then stream 0,4,8 and stall three cycles on 8
        cyc(1'b0, 1'b0, 32'h0, 1'b1);
        cyc(1'b0, 1'b0, 32'h0, 1'b1);
        run(4, 1'b1);
        run(3, 1'b0);
        run(4, 1'b1);

        // Aligned redirect while decode stalls
        cyc(1'b1, 1'b1, 32'h0000_0100, 1'b0);
        run(4, 1'b1);

        // Redirect to the top word: PC wraps to 0
        cyc(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1);
        run(4, 1'b1);

        // Reset during a stall with a valid word held
        run(3, 1'b0);
        cyc(1'b0, 1'b0, 32'h0, 1'b0);
        run(5, 1'b1);

        // Misaligned redirect: sticky fault, frozen PC, cleared by reset
        cyc(1'b1, 1'b1, 32'h0000_0102, 1'b1);
        run(10, 1'b1);
        cyc(1'b1, 1'b1, 32'h0000_0200, 1'b1);
        run(2, 1'b1);
        cyc(1'b0, 1'b0, 32'h0, 1'b1);
        run(5, 1'b1);

        // Redirect on the first cycle after reset release is ignored
        cyc(1'b0, 1'b0, 32'h0, 1'b1);
        cyc(1'b1, 1'b1, 32'h0000_0300, 1'b1);
        run(4, 1'b1);

        // Random traffic
        for (int unsigned i = 0; i < 4000; i++) begin
            t = $urandom & 32'h0000_FFFC;
            if ($urandom_range(3) == 0) t = 32'hFFFF_FF00 | (t & 32'h0000_00FC);
            if ($urandom_range(19) == 0) t[1:0] = 2'($urandom_range(3, 1));
            cyc(($urandom_range(99) != 0),
                ($urandom_range(9) == 0),
                t,
                ($urandom_range(9) < 7));
        end

        run(3, 1'b1);
        @(posedge clk);
        #2;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
